count_capture_fifo: RTL and testbench

- Downstream consumer of the 8-bit free-running counter: on a `capture` strobe it snapshots the counter's `value` into a small FIFO.
- Drains the FIFO to a consumer (CPU status/debug path) over a valid/ready handshake.
- Gives the vcpu a time-stamp/event log without stalling the counter.

---
 rtl/count_capture_fifo_pkg.sv | 13 +
 rtl/count_capture_fifo_if.sv | 11 +
 rtl/count_capture_fifo_sync_fifo_core.sv | 54 +++++
 rtl/count_capture_fifo.sv | 63 ++++++
 tb/tb_count_capture_fifo.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/count_capture_fifo_pkg.sv
// rtl/count_capture_fifo_pkg.sv - shared widths and sizing helper for the capture FIFO
package count_capture_fifo_pkg;

    localparam int CNT_WIDTH = 8;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // occupancy counter must represent 0..depth inclusive
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/count_capture_fifo_if.sv
// rtl/count_capture_fifo_if.sv - first-word fall-through drain handshake
interface count_capture_fifo_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/count_capture_fifo_sync_fifo_core.sv
// rtl/count_capture_fifo_sync_fifo_core.sv - storage, wrapping pointers and occupancy
module count_capture_fifo_sync_fifo_core
    import count_capture_fifo_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic                      push_ok,
    output logic [WIDTH-1:0]          head,
    output logic                      empty,
    output logic                      full,
    output logic [level_w(DEPTH)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // a pop frees the slot this same edge, so a full FIFO can still accept
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/count_capture_fifo.sv
// rtl/count_capture_fifo.sv - counter snapshot FIFO; COUNT_CAPTURE_DELTA_EN stores deltas
module count_capture_fifo
    import count_capture_fifo_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             value,
    input  logic                         capture,
    count_capture_fifo_if.master         out,
    output logic [level_w(DEPTH)-1:0]    level,
    output logic                         full,
    output logic                         overflow,
    input  logic                         overflow_clr
);
    logic             accepted;
    logic             empty;
    logic             drop;
    logic [WIDTH-1:0] din;

`ifdef COUNT_CAPTURE_DELTA_EN
    logic [WIDTH-1:0] prev;

    // modular subtraction makes counter wrap yield the true small delta
    assign din = value - prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         prev <= '0;
        else if (accepted) prev <= value;
    end
`else
    assign din = value;
`endif

    count_capture_fifo_sync_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (din),
        .pop       (out.out_ready),
        .push_ok   (accepted),
        .head      (out.out_data),
        .empty     (empty),
        .full      (full),
        .level     (level)
    );

    assign out.out_valid = !empty;
    assign drop          = capture && !accepted;

    // a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// tb/tb_count_capture_fifo.sv - directed vector bench for count_capture_fifo
module tb_count_capture_fifo;
    import count_capture_fifo_pkg::*;

    typedef struct {
        logic       cap;
        logic [7:0] val;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] el;
        logic       ef;
        logic       eo;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] value;
    logic       capture;
    logic [2:0] level;
    logic       full;
    logic       overflow;
    logic       overflow_clr;
    int         tests;
    int         fails;
    vec_t       vecs[$];

    count_capture_fifo_if #(.WIDTH(8)) out_if ();

    count_capture_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .value        (value),
        .capture      (capture),
        .out          (out_if),
        .level        (level),
        .full         (full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic [7:0] v, input logic r, input logic cl);
        capture          = c;
        value            = v;
        out_if.out_ready = r;
        overflow_clr     = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic [7:0] v, input logic r, input logic cl,
                       input logic ev, input logic [7:0] ed, input logic [2:0] el,
                       input logic ef, input logic eo);
        vec_t t;
        t.cap = c; t.val = v; t.rdy = r; t.clr = cl;
        t.ev = ev; t.ed = ed; t.el = el; t.ef = ef; t.eo = eo;
        vecs.push_back(t);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        capture = 1'b0;
        value = '0;
        out_if.out_ready = 1'b0;
        overflow_clr = 1'b0;
        #12;
        chk("rst.valid", out_if.out_valid, 0);
        chk("rst.level", level, 0);
        chk("rst.full", full, 0);
        chk("rst.ovf", overflow, 0);
        chk("rst.data", out_if.out_data, 0);
        reset = 1'b0;

        //   cap val rdy clr | valid data lvl full ovf
        add(1,  5, 0, 0,  1,  5, 1, 0, 0);
        add(0,  6, 0, 0,  1,  5, 1, 0, 0);
        add(0,  7, 0, 0,  1,  5, 1, 0, 0);
        add(0,  8, 0, 0,  1,  5, 1, 0, 0);
        add(0,  9, 1, 0,  0,  0, 0, 0, 0);
        add(1, 10, 0, 0,  1, 10, 1, 0, 0);
        add(1, 11, 0, 0,  1, 10, 2, 0, 0);
        add(1, 12, 0, 0,  1, 10, 3, 0, 0);
        add(1, 13, 0, 0,  1, 10, 4, 1, 0);
        add(1, 14, 0, 0,  1, 10, 4, 1, 1);
        add(0,  0, 1, 0,  1, 11, 3, 0, 1);
        add(0,  0, 1, 0,  1, 12, 2, 0, 1);
        add(0,  0, 1, 0,  1, 13, 1, 0, 1);
        add(0,  0, 1, 0,  0,  0, 0, 0, 1);
        add(0,  0, 0, 1,  0,  0, 0, 0, 0);
        add(1, 16, 0, 0,  1, 16, 1, 0, 0);
        add(1, 17, 0, 0,  1, 16, 2, 0, 0);
        add(1, 18, 0, 0,  1, 16, 3, 0, 0);
        add(1, 19, 0, 0,  1, 16, 4, 1, 0);
        add(1, 20, 1, 0,  1, 17, 4, 1, 0);
        add(0,  0, 1, 0,  1, 18, 3, 0, 0);
        add(0,  0, 1, 0,  1, 19, 2, 0, 0);
        add(0,  0, 1, 0,  1, 20, 1, 0, 0);
        add(0,  0, 1, 0,  0,  0, 0, 0, 0);
        add(1, 30, 0, 0,  1, 30, 1, 0, 0);
        add(1, 31, 0, 0,  1, 30, 2, 0, 0);
        add(1, 32, 0, 0,  1, 30, 3, 0, 0);
        add(1, 33, 0, 0,  1, 30, 4, 1, 0);
        add(1, 34, 0, 0,  1, 30, 4, 1, 1);
        add(1, 35, 0, 1,  1, 30, 4, 1, 1);
        add(0,  0, 0, 1,  1, 30, 4, 1, 0);
        add(0,  0, 0, 0,  1, 30, 4, 1, 0);
        add(0,  0, 1, 0,  1, 31, 3, 0, 0);
        add(0,  0, 1, 0,  1, 32, 2, 0, 0);
        add(0,  0, 1, 0,  1, 33, 1, 0, 0);
        add(0,  0, 1, 0,  0,  0, 0, 0, 0);
        add(0,  0, 1, 0,  0,  0, 0, 0, 0);
        add(1, 40, 1, 0,  1, 40, 1, 0, 0);
        add(1, 41, 1, 0,  1, 41, 1, 0, 0);
        add(0,  0, 1, 0,  0,  0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].cap, vecs[i].val, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("v%0d.valid", i), out_if.out_valid, vecs[i].ev);
            chk($sformatf("v%0d.level", i), level, vecs[i].el);
            chk($sformatf("v%0d.full", i), full, vecs[i].ef);
            chk($sformatf("v%0d.ovf", i), overflow, vecs[i].eo);
`ifndef COUNT_CAPTURE_DELTA_EN
            chk($sformatf("v%0d.data", i), out_if.out_data, vecs[i].ed);
`endif
        end

        // mid-run reset with two entries held and overflow set
        for (int i = 0; i < 5; i++) step(1, 8'(50 + i), 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("pre_rst.level", level, 2);
        chk("pre_rst.ovf", overflow, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst.valid", out_if.out_valid, 0);
        chk("async_rst.level", level, 0);
        chk("async_rst.ovf", overflow, 0);
        chk("async_rst.data", out_if.out_data, 0);
        step(1, 77, 0, 0);
        chk("held_rst.level", level, 0);
        reset = 1'b0;
        step(1, 60, 0, 0);
        chk("post_rst.level", level, 1);
        chk("post_rst.valid", out_if.out_valid, 1);
`ifndef COUNT_CAPTURE_DELTA_EN
        chk("post_rst.data", out_if.out_data, 60);
`endif

`ifdef COUNT_CAPTURE_DELTA_EN
        #2;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        step(1, 3, 0, 0);
        step(1, 7, 0, 0);
        step(1, 250, 0, 0);
        step(1, 4, 0, 0);
        chk("delta.level", level, 4);
        chk("delta.d0", out_if.out_data, 3);
        step(0, 0, 1, 0);
        chk("delta.d1", out_if.out_data, 4);
        step(0, 0, 1, 0);
        chk("delta.d2", out_if.out_data, 243);
        step(0, 0, 1, 0);
        chk("delta.d3", out_if.out_data, 10);
        step(0, 0, 1, 0);
        chk("delta.empty", out_if.out_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
